mod_pc_fetch: RTL and testbench
===============================

Name: mod_pc_fetch

Overview:
- PC register and instruction-fetch front end of the pipeline; the consumer of the next-PC unit's redirect (npc_on, pc_next).
- Holds the fetch PC and drives the instruction-memory handshake.
- Owns the IF/ID instruction latch and honours the hazard-unit stall.
- Latches a redirect that arrives while fetch cannot advance and applies it later, so no redirect is lost.
- Delayed-branch architecture: the delay-slot instruction is never flushed.

Parameters:
RESET_PC, 32'h0000_3000, fetch address after reset
NOP_INS, 32'h0000_0000, if_ins value for reset and bubbles

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold IF/ID and PC this cycle
npc_on  input  1  redirect request from next-PC unit
pc_next  input  32  redirect target, valid when npc_on=1
imem_ready  input  1  instruction memory: imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (= pc_now)
pc_now  output  32  current fetch PC
pc_plus4  output  32  pc_now + 4, combinational
if_pc  output  32  PC of instruction in IF/ID latch
if_ins  output  32  instruction in IF/ID latch
if_valid  output  1  IF/ID latch holds a real instruction
redirect_pending  output  1  a redirect is latched and not yet applied
misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc_now=RESET_PC; state=IDLE.
  - if_pc=0; if_ins=NOP_INS; if_valid=0.
  - redirect_pending=0; pend_target=0; misalign_err=0; inst_buf cleared.
- States: IDLE, FETCH, HOLD. imem_req=1 only in FETCH; imem_addr=pc_now always.
- IDLE: one cycle after reset release; unconditionally -> FETCH. Redirects during IDLE are latched (see below).
- Next-PC selection (sel), highest priority first:
  1. npc_on=1 -> pc_next
  2. redirect_pending=1 -> pend_target
  3. otherwise -> pc_now+4
- sel is written with bits [1:0] forced to 0. If the chosen target has bits [1:0] != 0, set misalign_err=1; it stays set until reset.
- FETCH, imem_ready=1, stall=0 (advance):
  - if_ins<=imem_rdata; if_pc<=pc_now; if_valid<=1.
  - pc_now<=sel; redirect_pending<=0. Stay in FETCH.
- FETCH, imem_ready=1, stall=1:
  - inst_buf<=imem_rdata; buf_pc<=pc_now.
  - IF/ID latch unchanged; pc_now unchanged. -> HOLD.
- FETCH, imem_ready=0, stall=0: if_valid<=0 (bubble); if_ins<=NOP_INS; pc_now unchanged.
- FETCH, imem_ready=0, stall=1: IF/ID latch and pc_now unchanged.
- HOLD:
  - stall=1: everything holds.
  - stall=0: if_ins<=inst_buf; if_pc<=buf_pc; if_valid<=1; pc_now<=sel; redirect_pending<=0. -> FETCH.
- Redirect latching: npc_on=1 in any cycle where pc_now does not advance -> pend_target<=pc_next, redirect_pending<=1. A later npc_on overwrites it (newest wins).
- Delay slot: the instruction fetched in the cycle npc_on is seen enters IF/ID normally. Only the fetch after it goes to the target. No flush output exists.
- Arithmetic: pc_plus4 is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Latency: imem_rdata accepted at edge N appears on if_ins after edge N. Redirect seen at edge N gives imem_addr=target after edge N.
- Reset mid-operation (mid-HOLD or with a redirect pending): full reset; the pending redirect and buffered instruction are discarded.

Test Plan:
- Reset release, imem_ready=1, no stall/redirect:
  - imem_addr sequence 0x3000, 0x3004, 0x3008.
  - if_valid first 1 one cycle after first req; if_pc=0x3000.
- npc_on=1, pc_next=0x3040 while fetching 0x3008:
  - if_pc=0x3008 (delay slot kept); next imem_addr=0x3040.
- stall=1 for 3 cycles with imem_ready=1 at 0x3010:
  - HOLD entered; if_* frozen; imem_req=0.
  - On release, if_ins=word@0x3010; imem_addr=0x3014.
- npc_on=1, pc_next=0x3100 during stall:
  - redirect_pending=1. On stall release, pending clears and imem_addr=0x3100.
- imem_ready=0 for 2 cycles:
  - if_valid=0, if_ins=NOP_INS; imem_addr held.
- pc_next=0x3102: imem_addr=0x3100 and misalign_err=1 until rst_n=0.
- rst_n=0 asserted mid-HOLD:
  - immediately pc_now=0x3000, if_valid=0, redirect_pending=0.

Source files
------------

// File: rtl/mod_pc_fetch_if.sv
// Instruction-memory handshake between the fetch front end (master) and the memory (slave).
interface mod_pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/mod_pc_fetch.sv
// Fetch PC register, instruction-memory request side and IF/ID latch for a
// delayed-branch pipeline; redirects that arrive while fetch is blocked are held.
module mod_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 npc_on,
    input  logic [31:0]          pc_next,
    mod_pc_fetch_if.master       imem,
    output logic [31:0]          pc_now,
    output logic [31:0]          pc_plus4,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_ins,
    output logic                 if_valid,
    output logic                 redirect_pending,
    output logic                 misalign_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pend_target;
    logic [31:0] inst_buf;
    logic [31:0] buf_pc;
    logic [31:0] sel_raw;
    logic [31:0] sel;

    logic        advance;
    logic        take_fetch;
    logic        take_buf;
    logic        capture_buf;
    logic        bubble;
    logic        latch_redirect;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        advance     = 1'b0;
        take_fetch  = 1'b0;
        take_buf    = 1'b0;
        capture_buf = 1'b0;
        bubble      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (imem.imem_ready && !stall) begin
                    take_fetch = 1'b1;
                    advance    = 1'b1;
                end else if (imem.imem_ready && stall) begin
                    // Word arrived but decode is frozen: park it until the stall lifts.
                    capture_buf = 1'b1;
                    state_nxt   = HOLD;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    take_buf  = 1'b1;
                    advance   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A live redirect beats a parked one; otherwise fall through sequentially.
    always_comb begin
        if (npc_on) begin
            sel_raw = pc_next;
        end else if (redirect_pending) begin
            sel_raw = pend_target;
        end else begin
            sel_raw = pc_plus4;
        end
        sel            = align_pc(sel_raw);
        latch_redirect = npc_on && !advance;
    end

    assign pc_plus4       = pc_now + 32'd4;
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_now           <= RESET_PC;
            redirect_pending <= 1'b0;
            pend_target      <= 32'd0;
            misalign_err     <= 1'b0;
        end else begin
            if (advance) begin
                pc_now           <= sel;
                redirect_pending <= 1'b0;
                if (is_misaligned(sel_raw)) begin
                    misalign_err <= 1'b1;
                end
            end else if (latch_redirect) begin
                pend_target      <= pc_next;
                redirect_pending <= 1'b1;
            end
        end
    end

    // IF/ID boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc    <= 32'd0;
            if_ins   <= NOP_INS;
            if_valid <= 1'b0;
            inst_buf <= NOP_INS;
            buf_pc   <= 32'd0;
        end else begin
            if (take_fetch) begin
                if_ins   <= imem.imem_rdata;
                if_pc    <= pc_now;
                if_valid <= 1'b1;
            end else if (take_buf) begin
                if_ins   <= inst_buf;
                if_pc    <= buf_pc;
                if_valid <= 1'b1;
            end else if (bubble) begin
                if_ins   <= NOP_INS;
                if_valid <= 1'b0;
            end
            if (capture_buf) begin
                inst_buf <= imem.imem_rdata;
                buf_pc   <= pc_now;
            end
        end
    end

endmodule

// File: tb/tb_mod_pc_fetch.sv
// Bench for mod_pc_fetch: cycle-by-cycle vector table plus reset and IDLE-redirect sequences.
module tb_mod_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        npc_on;
    logic [31:0] pc_next;
    logic [31:0] pc_now;
    logic [31:0] pc_plus4;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_valid;
    logic        redirect_pending;
    logic        misalign_err;

    int n_asrt = 0;
    int n_fail = 0;
    int step   = 0;

    mod_pc_fetch_if bus ();

    mod_pc_fetch #(
        .RESET_PC(32'h0000_3000),
        .NOP_INS (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .npc_on          (npc_on),
        .pc_next         (pc_next),
        .imem            (bus),
        .pc_now          (pc_now),
        .pc_plus4        (pc_plus4),
        .if_pc           (if_pc),
        .if_ins          (if_ins),
        .if_valid        (if_valid),
        .redirect_pending(redirect_pending),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: each word tagged with its own address.
    function automatic logic [31:0] wordf(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    assign bus.imem_rdata = wordf(bus.imem_addr);

    typedef struct {
        logic        stall;
        logic        npc_on;
        logic [31:0] pc_next;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_if_pc;
        logic [31:0] e_if_ins;
        logic        e_valid;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic s, input logic n, input logic [31:0] pn,
                                input logic r, input logic [31:0] epc, input logic ereq,
                                input logic [31:0] eifpc, input logic [31:0] eins,
                                input logic ev, input logic ep, input logic em);
        vec_t v;
        v.stall = s;   v.npc_on = n;   v.pc_next = pn;   v.ready = r;
        v.e_pc = epc;  v.e_req = ereq; v.e_if_pc = eifpc; v.e_if_ins = eins;
        v.e_valid = ev; v.e_pend = ep; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
        end
    endtask

    // Called at a negedge: drive, queue expectation, check after the rising edge.
    task automatic drive_vec(input vec_t v);
        vec_t e;
        stall          = v.stall;
        npc_on         = v.npc_on;
        pc_next        = v.pc_next;
        bus.imem_ready = v.ready;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc_now",   pc_now,           e.e_pc);
        chk("addr",     bus.imem_addr,    e.e_pc);
        chk("plus4",    pc_plus4,         e.e_pc + 32'd4);
        chk("req",      32'(bus.imem_req), 32'(e.e_req));
        chk("if_pc",    if_pc,            e.e_if_pc);
        chk("if_ins",   if_ins,           e.e_if_ins);
        chk("if_valid", 32'(if_valid),    32'(e.e_valid));
        chk("pending",  32'(redirect_pending), 32'(e.e_pend));
        chk("misalign", 32'(misalign_err), 32'(e.e_mis));
        step++;
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_pc",      pc_now,                 32'h0000_3000);
        chk("rst_req",     32'(bus.imem_req),      32'd0);
        chk("rst_if_pc",   if_pc,                  32'd0);
        chk("rst_if_ins",  if_ins,                 NOP);
        chk("rst_valid",   32'(if_valid),          32'd0);
        chk("rst_pending", 32'(redirect_pending),  32'd0);
        chk("rst_mis",     32'(misalign_err),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; npc_on = 1'b0; pc_next = 32'd0; bus.imem_ready = 1'b0;

        //          stall npc pc_next       rdy  e_pc          req if_pc         if_ins                  v  pend mis
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3000,     1, 32'h0,        NOP,                    0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3004,     1, 32'h3000,     wordf(32'h3000),        1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3008,     1, 32'h3004,     wordf(32'h3004),        1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h300C,     1, 32'h3008,     wordf(32'h3008),        1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3010,     1, 32'h300C,     wordf(32'h300C),        1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h3010,     0, 32'h300C,     wordf(32'h300C),        1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h3010,     0, 32'h300C,     wordf(32'h300C),        1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h3010,     0, 32'h300C,     wordf(32'h300C),        1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3014,     1, 32'h3010,     wordf(32'h3010),        1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3040,     1, 32'h3040,     1, 32'h3014,     wordf(32'h3014),        1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3044,     1, 32'h3040,     wordf(32'h3040),        1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h3044,     0, 32'h3040,     wordf(32'h3040),        1, 0, 0));
        tbl.push_back(mk(1, 1, 32'h3100,     1, 32'h3044,     0, 32'h3040,     wordf(32'h3040),        1, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h3044,     0, 32'h3040,     wordf(32'h3040),        1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3100,     1, 32'h3044,     wordf(32'h3044),        1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h3100,     1, 32'h3044,     NOP,                    0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3200,     0, 32'h3100,     1, 32'h3044,     NOP,                    0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3200,     1, 32'h3100,     wordf(32'h3100),        1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3102,     1, 32'h3100,     1, 32'h3200,     wordf(32'h3200),        1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3104,     1, 32'h3100,     wordf(32'h3100),        1, 0, 1));
        tbl.push_back(mk(1, 1, 32'h3300,     0, 32'h3104,     1, 32'h3100,     wordf(32'h3100),        1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h3400,     1, 32'h3400,     1, 32'h3104,     wordf(32'h3104),        1, 0, 1));
        tbl.push_back(mk(1, 1, 32'h3500,     0, 32'h3400,     1, 32'h3104,     wordf(32'h3104),        1, 1, 1));
        tbl.push_back(mk(1, 1, 32'h3600,     0, 32'h3400,     1, 32'h3104,     wordf(32'h3104),        1, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h3600,     1, 32'h3400,     wordf(32'h3400),        1, 0, 1));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h3600,    wordf(32'h3600),        1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC, wordf(32'hFFFF_FFFC),  1, 0, 1));

        repeat (2) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;

        foreach (tbl[i]) drive_vec(tbl[i]);

        // Enter HOLD with a redirect parked, then reset asynchronously mid-cycle.
        drive_vec(mk(1, 0, 32'h0,    1, 32'h0, 0, 32'hFFFF_FFFC, wordf(32'hFFFF_FFFC), 1, 0, 1));
        drive_vec(mk(1, 1, 32'h3700, 0, 32'h0, 0, 32'hFFFF_FFFC, wordf(32'hFFFF_FFFC), 1, 1, 1));
        #2 rst_n = 1'b0;
        #1 chk_reset_state();
        @(negedge clk);
        stall = 1'b0; npc_on = 1'b0; bus.imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect seen in IDLE is parked and taken on the first fetch; the old buffer is gone.
        drive_vec(mk(0, 1, 32'h3800, 0, 32'h3000, 1, 32'h0,    NOP,             0, 1, 0));
        drive_vec(mk(0, 0, 32'h0,    1, 32'h3800, 1, 32'h3000, wordf(32'h3000), 1, 0, 0));
        drive_vec(mk(0, 0, 32'h0,    1, 32'h3804, 1, 32'h3800, wordf(32'h3800), 1, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
